// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan counter: active-low segment
// patterns ordered {g,f,e,d,c,b,a}, the blank pattern and the all-off anode value.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Non-BCD codes cannot occur; they show as blank.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_counter.sv
// Four-digit BCD event counter with multiplexed seven-segment display.
// The upstream divider output is resynchronised, edge-detected into a tick,
// and each tick advances the digit scan and a prescaled decimal count.
module seg7_scan_counter
  import seg7_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        slow,
  input  logic        en,
  input  logic        clr,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [15:0] bcd,
  output logic        wrap
);

  localparam logic [9:0] PreMax = 10'(COUNT_DIV - 1);

  logic        s1_q, s2_q, s3_q;
  logic        tick;
  logic [1:0]  idx_q;
  logic [9:0]  pre_q, pre_d;
  logic [15:0] bcd_q, bcd_d, bcd_inc;
  logic        wrap_q, wrap_d;
  logic        carry;
  logic [3:0]  digit;
  logic [6:0]  digit_seg;
  logic        blank;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;

  assign tick = s2_q & ~s3_q;

  // Two-flop synchroniser followed by an edge-detect flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= slow;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Scan index advances on every tick regardless of en/clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= 2'd0;
    end else if (tick) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // Decimal ripple increment, prescaler and clear; clr wins over counting.
  always_comb begin
    pre_d   = pre_q;
    bcd_d   = bcd_q;
    wrap_d  = 1'b0;
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    if (clr) begin
      pre_d = 10'd0;
      bcd_d = 16'h0000;
    end else if (en && tick) begin
      if (pre_q == PreMax) begin
        pre_d  = 10'd0;
        bcd_d  = bcd_inc;
        // Carry out of digit 3 means 9999 rolled to 0000.
        wrap_d = carry;
      end else begin
        pre_d = pre_q + 10'd1;
      end
    end
  end

  // Count state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= 10'd0;
      bcd_q  <= 16'h0000;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

  assign digit = bcd_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .digit (digit),
    .seg   (digit_seg)
  );

  // Leading-zero blanking: a digit blanks when it and all higher digits are zero.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd1:    blank = (bcd_q[15:4] == 12'd0);
      2'd2:    blank = (bcd_q[15:8] == 8'd0);
      2'd3:    blank = (bcd_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end

  // Display output registers, one cycle behind idx/bcd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= blank ? SEG_BLANK : digit_seg;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign bcd  = bcd_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Directed self-checking bench for seg7_scan_counter. Two instances share all
// inputs: one with COUNT_DIV=1 and one with COUNT_DIV=4.
module tb_seg7_scan_counter;

  localparam logic [6:0] B0  = 7'b1000000;
  localparam logic [6:0] B1  = 7'b1111001;
  localparam logic [6:0] B2  = 7'b0100100;
  localparam logic [6:0] B3  = 7'b0110000;
  localparam logic [6:0] B4  = 7'b0011001;
  localparam logic [6:0] B5  = 7'b0010010;
  localparam logic [6:0] B6  = 7'b0000010;
  localparam logic [6:0] B7  = 7'b1111000;
  localparam logic [6:0] B8  = 7'b0000000;
  localparam logic [6:0] B9  = 7'b0010000;
  localparam logic [6:0] BLK = 7'h7F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slow = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  an1, an4;
  logic [6:0]  seg1, seg4;
  logic [15:0] bcd1, bcd4;
  logic        wrap1, wrap4;

  int checks = 0;
  int failures = 0;
  int tb_idx = 0;

  typedef struct {
    int              edges;
    logic [15:0]     b1;
    logic [15:0]     b4;
    logic [3:0][6:0] s1;
    logic [3:0][6:0] s4;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  seg7_scan_counter #(.COUNT_DIV(1)) u_d1 (
    .clk  (clk),
    .rst  (rst),
    .slow (slow),
    .en   (en),
    .clr  (clr),
    .an   (an1),
    .seg  (seg1),
    .bcd  (bcd1),
    .wrap (wrap1)
  );

  seg7_scan_counter #(.COUNT_DIV(4)) u_d4 (
    .clk  (clk),
    .rst  (rst),
    .slow (slow),
    .en   (en),
    .clr  (clr),
    .an   (an4),
    .seg  (seg4),
    .bcd  (bcd4),
    .wrap (wrap4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after a negedge; one rising edge of slow, returns once an/seg settle.
  task automatic pulse_edge();
    slow = 1'b1;
    repeat (2) @(negedge clk);
    slow = 1'b0;
    repeat (2) @(negedge clk);
    tb_idx++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tb_idx = 0;
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [3:0] an_exp(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] wpat1, wpat4;
    int d;

    vecs[0] = '{edges: 7,    b1: 16'h0007, b4: 16'h0001,
                s1: {BLK, BLK, BLK, B7}, s4: {BLK, BLK, BLK, B1}};
    vecs[1] = '{edges: 100,  b1: 16'h0100, b4: 16'h0025,
                s1: {BLK, B1, B0, B0},   s4: {BLK, BLK, B2, B5}};
    vecs[2] = '{edges: 1383, b1: 16'h1383, b4: 16'h0345,
                s1: {B1, B3, B8, B3},    s4: {BLK, B3, B4, B5}};
    vecs[3] = '{edges: 987,  b1: 16'h0987, b4: 16'h0246,
                s1: {BLK, B9, B8, B7},   s4: {BLK, B2, B4, B6}};

    // Reset state held across clock edges.
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an1), 32'hF);
    check("rst_seg", 32'(seg1), 32'h7F);
    check("rst_bcd", 32'(bcd1), 32'h0);
    check("rst_wrap", 32'(wrap1), 32'h0);
    check("rst_an4", 32'(an4), 32'hF);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Prescale.
    repeat (40) pulse_edge();
    check("pre_bcd1", 32'(bcd1), 32'h0040);
    check("pre_bcd4", 32'(bcd4), 32'h0010);
    check("pre_pre4", 32'(u_d4.pre_q), 32'd0);
    // Held high: only the rising edge counts.
    slow = 1'b1;
    repeat (100) @(negedge clk);
    tb_idx++;
    check("hold_bcd1", 32'(bcd1), 32'h0041);
    check("hold_pre4", 32'(u_d4.pre_q), 32'd1);
    slow = 1'b0;
    repeat (2) @(negedge clk);
    pulse_edge();
    check("mid_bcd1", 32'(bcd1), 32'h0042);
    check("mid_bcd4", 32'(bcd4), 32'h0010);
    check("mid_pre4", 32'(u_d4.pre_q), 32'd2);

    // Asynchronous reset mid-count, sampled before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_bcd1", 32'(bcd1), 32'h0);
    check("arst_an1", 32'(an1), 32'hF);
    check("arst_seg1", 32'(seg1), 32'h7F);
    check("arst_pre4", 32'(u_d4.pre_q), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tb_idx = 0;
    repeat (3) @(negedge clk);

    // clr coincident with a tick.
    repeat (19) pulse_edge();
    check("pclr_bcd1", 32'(bcd1), 32'h0019);
    check("pclr_bcd4", 32'(bcd4), 32'h0004);
    check("pclr_pre4", 32'(u_d4.pre_q), 32'd3);
    slow = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    slow = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    tb_idx++;
    check("clr_bcd1", 32'(bcd1), 32'h0);
    check("clr_pre1", 32'(u_d1.pre_q), 32'd0);
    check("clr_bcd4", 32'(bcd4), 32'h0);
    check("clr_pre4", 32'(u_d4.pre_q), 32'd0);
    check("clr_idx", 32'(u_d1.idx_q), 32'(tb_idx % 4));
    @(negedge clk);
    check("clr_an", 32'(an1), 32'(an_exp(tb_idx % 4)));

    // Enable hold while scanning continues.
    repeat (5) pulse_edge();
    check("en_bcd1", 32'(bcd1), 32'h0005);
    check("en_pre4", 32'(u_d4.pre_q), 32'd1);
    en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pulse_edge();
      check("hold_an", 32'(an1), 32'(an_exp(tb_idx % 4)));
      check("hold_bcd", 32'(bcd1), 32'h0005);
      check("hold_pre", 32'(u_d4.pre_q), 32'd1);
    end
    en = 1'b1;

    // Rollover.
    do_reset();
    repeat (9999) pulse_edge();
    check("roll_bcd1", 32'(bcd1), 32'h9999);
    check("roll_bcd4", 32'(bcd4), 32'h2499);
    check("roll_pre4", 32'(u_d4.pre_q), 32'd3);
    wpat1 = '0;
    wpat4 = '0;
    slow = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) slow = 1'b0;
      wpat1[c] = wrap1;
      wpat4[c] = wrap4;
    end
    tb_idx++;
    check("wrap_pat1", 32'(wpat1), 32'h04);
    check("wrap_pat4", 32'(wpat4), 32'h00);
    check("wrap_bcd1", 32'(bcd1), 32'h0000);
    check("wrap_bcd4", 32'(bcd4), 32'h2500);

    // Blanking and decode table.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      en = 1'b1;
      repeat (vecs[v].edges) pulse_edge();
      check("tbl_bcd1", 32'(bcd1), 32'(vecs[v].b1));
      check("tbl_bcd4", 32'(bcd4), 32'(vecs[v].b4));
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
        pulse_edge();
        d = tb_idx % 4;
        check("tbl_an", 32'(an1), 32'(an_exp(d)));
        check("tbl_seg1", 32'(seg1), 32'(vecs[v].s1[d]));
        check("tbl_seg4", 32'(seg4), 32'(vecs[v].s4[d]));
      end
      en = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_counter.md
# seg7_scan_counter

Four-digit BCD event counter with a multiplexed seven-segment display driver. It sits directly downstream of the slow-clock divider and consumes that divider's toggling output as a timing reference. It resynchronises that output into the system clock domain and turns each rising edge into a one-cycle tick. Ticks drive both the digit-scan rotation and a prescaled decimal count.

## Interface
- `COUNT_DIV`, default 100: number of ticks per BCD increment; legal range 1..1023.
- `clk` in 1: system clock; all state is updated on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `slow` in 1: toggling output of the upstream divider; treated as asynchronous.
- `en` in 1: count enable; display scanning is unaffected by it.
- `clr` in 1: synchronous clear of count and prescaler.
- `an` out 4: digit enables, active-low; `an[i]` selects digit i (digit 0 = least significant).
- `seg` out 7: segments, active-low, ordered {g,f,e,d,c,b,a}.
- `bcd` out 16: count value, 4 BCD digits, digit 0 in `bcd[3:0]`.
- `wrap` out 1: one-cycle pulse on the 9999→0000 rollover.

## Operation
- Synchroniser: `slow` passes through two flops (s1, s2), then an edge flop s3. `tick = s2 & ~s3`, combinational, high for exactly one `clk` cycle per `slow` rising edge. Falling edges are ignored.
- Scan index `idx` (2 bits): increments on each tick and wraps 3→0. It is never affected by `en` or `clr`.
- Prescaler `pre` (10 bits), when `en` = 1 and tick = 1:
  - if `pre` = COUNT_DIV-1: `pre` → 0 and `bcd` increments;
  - otherwise `pre` increments.
- With `en` = 0, `pre` and `bcd` hold.
- BCD increment is a decimal ripple: each digit at 9 goes to 0 and carries into the next digit.
  - 9999 → 0000; `wrap` = 1 in the following cycle only.
- `clr` = 1 takes priority over an increment in the same cycle: `bcd` → 0, `pre` → 0, `wrap` → 0.
- Display registers: `an` = ~(1 << idx); `seg` = decode of `bcd` digit `idx`.
- Leading-zero blanking: digits 3..1 show `seg` = 7'h7F when that digit and all higher digits are 0. Digit 0 is always shown.
- Decode table (gfedcba, active-low):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
- Non-BCD digit codes are unreachable; they decode to 7'h7F.

## Timing
- Reset values, applied immediately on `rst` assertion, including mid-count:
  - s1, s2, s3 = 0
  - `idx` = 0, `pre` = 0, `bcd` = 16'h0000, `wrap` = 0
  - `an` = 4'b1111, `seg` = 7'h7F
- Reset release: the first tick may occur no earlier than the third `clk` edge after deassertion.
- Latency, where E0 is the first edge sampling `slow` = 1:
  - tick is high between E1 and E2;
  - `idx`, `pre`, `bcd` and `wrap` update at E2;
  - `an` and `seg` reflect the new state at E3.
- `bcd` and `wrap` are registered outputs. `an` and `seg` are registered from `idx` and `bcd`, so they lag by one cycle.
- `slow` must remain stable for at least 2 `clk` periods per level. Faster toggling is out of specification.
- Simultaneous tick and `clr`: `idx` advances; count clears.

## Structure
- Shared package `seg7_pkg` holds:
  - the ten active-low segment constants;
  - `SEG_BLANK` = 7'h7F;
  - `AN_OFF` = 4'b1111.
- One combinational sub-module, `seg7_decode`: 4-bit BCD in → 7-bit active-low segments out, using the package constants.
- The top level holds the synchroniser, prescaler, BCD counter, scan index, blanking logic and output registers.

## Test plan
- Reset mid-count: `COUNT_DIV` = 1, 42 `slow` edges → `bcd` = 16'h0042; assert `rst` → `bcd` = 0, `an` = 4'b1111, `seg` = 7'h7F without waiting for a `clk` edge.
- Prescale: `COUNT_DIV` = 4, `en` = 1, 40 `slow` rising edges → `bcd` = 16'h0010 and `pre` = 0; `slow` held high for 100 cycles → no further change.
- Rollover: `COUNT_DIV` = 1, 10000 edges → `bcd` = 16'h0000; `wrap` is high for exactly one cycle, two cycles after the 10000th synchronised edge.
- `clr` vs tick: `clr` asserted in the same cycle as a tick that would take `bcd` from 0x0019 to 0x0020 → `bcd` = 0, `pre` = 0, `idx` still advances.
- Enable hold: `en` = 0 over 8 ticks → `bcd` and `pre` unchanged; `an` steps 1110 → 1101 → 1011 → 0111 → 1110.
- Blanking and decode:
  - `bcd` = 0x0007 → digits 3..1 show 7'h7F; digit 0 shows 1111000.
  - `bcd` = 0x0100 → digit 3 shows 7'h7F; digit 2 shows 1111001; digits 1 and 0 show 1000000.
